// File: rtl/sl_preceptron_host_driver_if.sv
// Bus between the host driver and the perceptron top: weight SRAM write port,
// lane data stream and the status readback the driver samples.
interface sl_preceptron_host_driver_if #(
    parameter int DATA_IN_LANES  = 4,
    parameter int DATA_IN_WIDTH  = 8,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int WEIGHTS_WIDTH  = 8,
    parameter int SUM_WIDTH      = 24
);
    logic                                    mem_wen;
    logic                                    mem_ren;
    logic [MEM_ADDR_WIDTH-1:0]               mem_addr;
    logic [WEIGHTS_WIDTH-1:0]                mem_wdata;
    logic                                    data_valid;
    logic [DATA_IN_WIDTH*DATA_IN_LANES-1:0]  data_in;
    logic [SUM_WIDTH-1:0]                    status_ai_sum;
    logic                                    status_ai_comparator;

    modport master (
        output mem_wen, mem_ren, mem_addr, mem_wdata, data_valid, data_in,
        input  status_ai_sum, status_ai_comparator
    );

    modport slave (
        input  mem_wen, mem_ren, mem_addr, mem_wdata, data_valid, data_in,
        output status_ai_sum, status_ai_comparator
    );
endinterface

// File: rtl/sl_preceptron_host_driver.sv
// Host-side initiator for the perceptron: loads a weight vector into its SRAM,
// streams one input vector, waits a fixed latency and returns sum/comparator.
module sl_preceptron_host_driver #(
    parameter int DATA_IN_LANES  = 4,
    parameter int DATA_IN_WIDTH  = 8,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int WEIGHTS_WIDTH  = 8,
    parameter int VECTOR_LENGTH  = 64,
    parameter int SUM_WIDTH      = 24,
    parameter int WEIGHT_BASE    = 0,
    parameter int RESULT_WAIT    = 96
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start_load,
    input  logic                                   start_infer,
    output logic                                   busy,
    output logic                                   cmd_dropped,
    input  logic                                   s_w_valid,
    output logic                                   s_w_ready,
    input  logic [WEIGHTS_WIDTH-1:0]               s_w_data,
    input  logic                                   s_v_valid,
    output logic                                   s_v_ready,
    input  logic [DATA_IN_WIDTH*DATA_IN_LANES-1:0] s_v_data,
    sl_preceptron_host_driver_if.master            pcp,
    output logic                                   m_res_valid,
    input  logic                                   m_res_ready,
    output logic [SUM_WIDTH-1:0]                   m_res_sum,
    output logic                                   m_res_cmp
);
    localparam int BEAT_W = DATA_IN_WIDTH * DATA_IN_LANES;
    localparam int BEATS  = VECTOR_LENGTH / DATA_IN_LANES;
    localparam int WCW    = $clog2(VECTOR_LENGTH + 1);
    localparam int BCW    = $clog2(BEATS + 1);
    localparam int TCW    = $clog2(RESULT_WAIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM,
        ST_WAIT,
        ST_RESULT
    } state_t;

    state_t                    state_q, state_d;
    logic [WCW-1:0]            wcnt_q, wcnt_d;
    logic [BCW-1:0]            bcnt_q, bcnt_d;
    logic [TCW-1:0]            wait_q, wait_d;
    logic                      mem_wen_q, mem_wen_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WEIGHTS_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                      data_valid_q, data_valid_d;
    logic [BEAT_W-1:0]         data_in_q, data_in_d;
    logic [SUM_WIDTH-1:0]      res_sum_q, res_sum_d;
    logic                      res_cmp_q, res_cmp_d;
    logic                      cmd_dropped_q, cmd_dropped_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wcnt_q        <= '0;
            bcnt_q        <= '0;
            wait_q        <= '0;
            mem_wen_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            data_valid_q  <= 1'b0;
            data_in_q     <= '0;
            res_sum_q     <= '0;
            res_cmp_q     <= 1'b0;
            cmd_dropped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            bcnt_q        <= bcnt_d;
            wait_q        <= wait_d;
            mem_wen_q     <= mem_wen_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            data_valid_q  <= data_valid_d;
            data_in_q     <= data_in_d;
            res_sum_q     <= res_sum_d;
            res_cmp_q     <= res_cmp_d;
            cmd_dropped_q <= cmd_dropped_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        bcnt_d        = bcnt_q;
        wait_d        = wait_q;
        mem_wen_d     = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        data_valid_d  = 1'b0;
        data_in_d     = data_in_q;
        res_sum_d     = res_sum_q;
        res_cmp_d     = res_cmp_q;
        cmd_dropped_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Load wins a tie; the losing infer command is reported as dropped.
                if (start_load) begin
                    state_d       = ST_LOAD_W;
                    wcnt_d        = '0;
                    cmd_dropped_d = start_infer;
                end else if (start_infer) begin
                    state_d = ST_STREAM;
                    bcnt_d  = '0;
                end
            end
            ST_LOAD_W: begin
                if (s_w_valid) begin
                    mem_wen_d   = 1'b1;
                    mem_addr_d  = MEM_ADDR_WIDTH'(WEIGHT_BASE) + MEM_ADDR_WIDTH'(wcnt_q);
                    mem_wdata_d = s_w_data;
                    wcnt_d      = wcnt_q + WCW'(1);
                    if (wcnt_q == WCW'(VECTOR_LENGTH - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STREAM: begin
                if (s_v_valid) begin
                    data_valid_d = 1'b1;
                    data_in_d    = s_v_data;
                    bcnt_d       = bcnt_q + BCW'(1);
                    if (bcnt_q == BCW'(BEATS - 1)) begin
                        state_d = ST_WAIT;
                        wait_d  = TCW'(RESULT_WAIT);
                    end
                end
            end
            ST_WAIT: begin
                // Sampling on the count-of-one cycle puts the capture edge
                // RESULT_WAIT cycles after the last data_valid cycle.
                if (wait_q <= TCW'(1)) begin
                    res_sum_d = pcp.status_ai_sum;
                    res_cmp_d = pcp.status_ai_comparator;
                    state_d   = ST_RESULT;
                end else begin
                    wait_d = wait_q - TCW'(1);
                end
            end
            ST_RESULT: begin
                if (m_res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && (start_load || start_infer)) begin
            cmd_dropped_d = 1'b1;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign s_w_ready   = (state_q == ST_LOAD_W);
    assign s_v_ready   = (state_q == ST_STREAM);
    assign m_res_valid = (state_q == ST_RESULT);
    assign m_res_sum   = res_sum_q;
    assign m_res_cmp   = res_cmp_q;
    assign cmd_dropped = cmd_dropped_q;

    // Reads are never issued, so the perceptron's SRAM lock is never contended.
    assign pcp.mem_ren    = 1'b0;
    assign pcp.mem_wen    = mem_wen_q;
    assign pcp.mem_addr   = mem_addr_q;
    assign pcp.mem_wdata  = mem_wdata_q;
    assign pcp.data_valid = data_valid_q;
    assign pcp.data_in    = data_in_q;

endmodule

// File: tb/tb_sl_preceptron_host_driver.sv
// Randomised bench for sl_preceptron_host_driver against a stand-in perceptron
// and a dot-product reference model built from the host-side vectors.
module tb_sl_preceptron_host_driver;
    localparam int L      = 4;
    localparam int DW     = 8;
    localparam int AW     = 16;
    localparam int WW     = 8;
    localparam int VL     = 64;
    localparam int SW     = 24;
    localparam int BASE   = 16'hFFF0;
    localparam int RW     = 96;
    localparam int BEATS  = VL / L;
    localparam int THRESH = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_load = 1'b0, start_infer = 1'b0;
    logic            busy, cmd_dropped;
    logic            s_w_valid = 1'b0, s_w_ready;
    logic [WW-1:0]   s_w_data = '0;
    logic            s_v_valid = 1'b0, s_v_ready;
    logic [L*DW-1:0] s_v_data = '0;
    logic            m_res_valid, m_res_ready = 1'b1, m_res_cmp;
    logic [SW-1:0]   m_res_sum;

    sl_preceptron_host_driver_if #(
        .DATA_IN_LANES(L), .DATA_IN_WIDTH(DW), .MEM_ADDR_WIDTH(AW),
        .WEIGHTS_WIDTH(WW), .SUM_WIDTH(SW)
    ) pif ();

    sl_preceptron_host_driver #(
        .DATA_IN_LANES(L), .DATA_IN_WIDTH(DW), .MEM_ADDR_WIDTH(AW),
        .WEIGHTS_WIDTH(WW), .VECTOR_LENGTH(VL), .SUM_WIDTH(SW),
        .WEIGHT_BASE(BASE), .RESULT_WAIT(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_load(start_load), .start_infer(start_infer),
        .busy(busy), .cmd_dropped(cmd_dropped),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
        .s_v_valid(s_v_valid), .s_v_ready(s_v_ready), .s_v_data(s_v_data),
        .pcp(pif),
        .m_res_valid(m_res_valid), .m_res_ready(m_res_ready),
        .m_res_sum(m_res_sum), .m_res_cmp(m_res_cmp)
    );

    always #5 clk = ~clk;

    // Stand-in perceptron: weight SRAM plus a lane-wise multiply-accumulate.
    logic [WW-1:0] wmem [0:65535];
    logic [SW-1:0] pc_sum = '0, pc_tmp;
    int            pc_idx = 0;
    logic          pc_clear = 1'b0;

    always @(posedge clk) begin
        if (pif.mem_wen) wmem[pif.mem_addr] <= pif.mem_wdata;
        if (pc_clear) begin
            pc_sum <= '0;
            pc_idx <= 0;
        end else if (pif.data_valid) begin
            pc_tmp = pc_sum;
            for (int l = 0; l < L; l++)
                pc_tmp = pc_tmp + SW'(pif.data_in[l*DW +: DW]) * SW'(wmem[AW'(BASE + pc_idx + l)]);
            pc_sum <= pc_tmp;
            pc_idx <= pc_idx + L;
        end
    end
    assign pif.status_ai_sum        = pc_sum;
    assign pif.status_ai_comparator = (pc_sum > SW'(THRESH));

    // Monitor: records every write and beat the driver puts on the bus.
    int                    cyc = 0;
    int                    last_dv_cyc = 0;
    int                    n_drop = 0;
    logic [AW+WW-1:0]      got_w[$];
    logic [L*DW-1:0]       got_v[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (pif.mem_wen) got_w.push_back({pif.mem_addr, pif.mem_wdata});
        if (pif.data_valid) begin
            got_v.push_back(pif.data_in);
            last_dv_cyc = cyc;
        end
        if (cmd_dropped) n_drop++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Reference data held by the host side.
    logic [WW-1:0]   ref_w [VL];
    logic [L*DW-1:0] ref_v [BEATS];

    function automatic logic [SW-1:0] ref_dot();
        int acc = 0;
        for (int i = 0; i < VL; i++) begin
            logic [L*DW-1:0] beat = ref_v[i / L];
            acc += int'(beat[(i % L)*DW +: DW]) * int'(ref_w[i]);
        end
        return SW'(acc);
    endfunction

    task automatic pulse(input logic ld, input logic inf);
        start_load = ld;
        start_infer = inf;
        @(posedge clk); #1;
        start_load = 1'b0;
        start_infer = 1'b0;
    endtask

    task automatic send_weight(input logic [WW-1:0] w, input logic throttle);
        logic hs = 1'b0;
        if (throttle) begin
            s_w_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_w_valid = 1'b1;
        s_w_data  = w;
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge clk);
            hs = s_w_ready;
            @(posedge clk); #1;
        end
        s_w_valid = 1'b0;
        if (!hs) check_eq("w_hs_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_beat(input logic [L*DW-1:0] b, input logic bubble);
        logic hs = 1'b0;
        if (bubble) begin
            s_v_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_v_valid = 1'b1;
        s_v_data  = b;
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge clk);
            hs = s_v_ready;
            @(posedge clk); #1;
        end
        s_v_valid = 1'b0;
        if (!hs) check_eq("v_hs_timeout", 64'd0, 64'd1);
    endtask

    // Streams ref_w after a load command has been accepted and checks the writes.
    task automatic load_and_check(input string tag, input logic throttle);
        int bad = 0;
        got_w.delete();
        for (int i = 0; i < VL; i++) send_weight(ref_w[i], throttle);
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
        check_eq({tag, "_wready_after"}, 64'(s_w_ready), 64'd0);
        check_eq({tag, "_final_wen_idle"}, 64'(pif.mem_wen), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_nwrites"}, 64'(got_w.size()), 64'(VL));
        for (int i = 0; i < VL && i < got_w.size(); i++)
            if (got_w[i] !== {AW'(BASE + i), ref_w[i]}) bad++;
        check_eq({tag, "_write_mismatches"}, 64'(bad), 64'd0);
    endtask

    task automatic reset_outputs_check(input string tag);
        check_eq({tag, "_ctrl"}, 64'({busy, cmd_dropped, s_w_ready, s_v_ready, pif.mem_wen,
                                      pif.mem_ren, pif.data_valid, m_res_valid, m_res_cmp}), 64'd0);
        check_eq({tag, "_mem_addr"}, 64'(pif.mem_addr), 64'd0);
        check_eq({tag, "_mem_wdata"}, 64'(pif.mem_wdata), 64'd0);
        check_eq({tag, "_data_in"}, 64'(pif.data_in), 64'd0);
        check_eq({tag, "_res_sum"}, 64'(m_res_sum), 64'd0);
    endtask

    // Streams ref_v, waits for the result and compares against the dot product.
    task automatic infer_and_check(input string tag, input logic bubbles, input logic hold_ready);
        logic          seen = 1'b0;
        int            lat = 0;
        logic [SW-1:0] exp_sum = ref_dot();
        logic [SW-1:0] s0;
        int            bad = 0, unstable = 0, drop0;
        pc_clear = 1'b1;
        @(posedge clk); #1;
        pc_clear = 1'b0;
        got_v.delete();
        m_res_ready = hold_ready;
        pulse(1'b0, 1'b1);
        for (int b = 0; b < BEATS; b++) send_beat(ref_v[b], bubbles && ($urandom_range(0, 1) == 1));
        for (int t = 0; t < RW + 20 && !seen; t++) begin
            @(negedge clk);
            if (m_res_valid) begin
                seen = 1'b1;
                lat  = cyc - last_dv_cyc;
            end
        end
        check_eq({tag, "_res_seen"}, 64'(seen), 64'd1);
        check_eq({tag, "_latency"}, 64'(lat), 64'(RW));
        check_eq({tag, "_nbeats"}, 64'(got_v.size()), 64'(BEATS));
        for (int b = 0; b < BEATS && b < got_v.size(); b++)
            if (got_v[b] !== ref_v[b]) bad++;
        check_eq({tag, "_beat_mismatches"}, 64'(bad), 64'd0);
        check_eq({tag, "_sum"}, 64'(m_res_sum), 64'(exp_sum));
        check_eq({tag, "_cmp"}, 64'(m_res_cmp), 64'(exp_sum > SW'(THRESH)));
        if (hold_ready) begin
            @(negedge clk);
            check_eq({tag, "_valid_one_cycle"}, 64'(m_res_valid), 64'd0);
            check_eq({tag, "_sum_held"}, 64'(m_res_sum), 64'(exp_sum));
        end else begin
            s0    = m_res_sum;
            drop0 = n_drop;
            got_v.delete();
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                start_infer = (k == 5);
                @(negedge clk);
                if (m_res_valid !== 1'b1 || m_res_sum !== s0) unstable++;
            end
            start_infer = 1'b0;
            check_eq({tag, "_bp_unstable"}, 64'(unstable), 64'd0);
            check_eq({tag, "_bp_dropped"}, 64'(n_drop - drop0), 64'd1);
            check_eq({tag, "_bp_no_dv"}, 64'(got_v.size()), 64'd0);
            @(posedge clk); #1;
            m_res_ready = 1'b1;
            @(posedge clk); #1;
            check_eq({tag, "_bp_released"}, 64'(m_res_valid), 64'd0);
        end
    endtask

    initial begin
        int drop0;
        #1;
        reset_outputs_check("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back load of 0x01..0x40, addresses wrapping past 0xFFFF.
        for (int i = 0; i < VL; i++) ref_w[i] = WW'(i + 1);
        pulse(1'b1, 1'b0);
        load_and_check("load_b2b", 1'b0);

        // Throttled load with random weights.
        for (int i = 0; i < VL; i++) ref_w[i] = WW'($urandom_range(0, 255));
        pulse(1'b1, 1'b0);
        load_and_check("load_thr", 1'b1);

        // All-ones weights and data give sum 64.
        for (int i = 0; i < VL; i++) ref_w[i] = 8'h01;
        pulse(1'b1, 1'b0);
        load_and_check("load_ones", 1'b0);
        for (int b = 0; b < BEATS; b++) ref_v[b] = 32'h0101_0101;
        infer_and_check("infer_ones", 1'b0, 1'b1);
        check_eq("infer_ones_sum64", 64'(m_res_sum), 64'd64);

        // Simultaneous commands: load wins, one drop, no stream activity.
        for (int i = 0; i < VL; i++) ref_w[i] = WW'($urandom_range(0, 15));
        drop0 = n_drop;
        got_v.delete();
        pulse(1'b1, 1'b1);
        check_eq("simul_in_load", 64'({busy, s_w_ready, s_v_ready}), 64'b110);
        load_and_check("simul_load", 1'b0);
        check_eq("simul_dropped", 64'(n_drop - drop0), 64'd1);
        check_eq("simul_no_dv", 64'(got_v.size()), 64'd0);

        // Random inferences; one all-zero vector exercises comparator = 0.
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < BEATS; b++)
                ref_v[b] = (r == 1) ? '0 : (L*DW)'($urandom);
            infer_and_check($sformatf("infer_rnd%0d", r), 1'b1, 1'b1);
        end

        // Result backpressure with a dropped command in the window.
        for (int b = 0; b < BEATS; b++) ref_v[b] = (L*DW)'($urandom);
        infer_and_check("infer_bp", 1'b1, 1'b0);

        // Asynchronous reset mid-stream, then a complete inference.
        for (int b = 0; b < BEATS; b++) ref_v[b] = (L*DW)'($urandom);
        pulse(1'b0, 1'b1);
        for (int b = 0; b < 5; b++) send_beat(ref_v[b], 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        reset_outputs_check("async_rst");
        @(posedge clk); #3;
        rst_n = 1'b1;
        got_v.delete();
        repeat (3) @(posedge clk);
        #1;
        check_eq("async_rst_no_resume", 64'({busy, s_v_ready}), 64'd0);
        check_eq("async_rst_no_dv", 64'(got_v.size()), 64'd0);
        infer_and_check("infer_after_rst", 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sl_preceptron_host_driver.md
Name: sl_preceptron_host_driver

Overview:
- Host-side initiator that drives the perceptron top's external interfaces.
- Loads a weight vector into the weight SRAM over the mem_* write port, then streams one input vector over the lane interface (data_valid/data_in).
- Waits a fixed latency, then samples status_ai_sum and status_ai_comparator and returns them to the host over a valid/ready result port.
- Sits between the host/testbench and the perceptron top: the transmitting end of the perceptron's data and weight interfaces.

Parameters:
- DATA_IN_LANES, 4, lanes per data beat
- DATA_IN_WIDTH, 8, bits per lane
- MEM_ADDR_WIDTH, 16, weight SRAM address width
- WEIGHTS_WIDTH, 8, weight width
- VECTOR_LENGTH, 64, elements per vector; must be a multiple of DATA_IN_LANES
- SUM_WIDTH, 24, result sum width
- WEIGHT_BASE, 0, first SRAM address written
- RESULT_WAIT, 96, cycles from the last data beat to result sampling; must be ≥1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_load  in  1  one-cycle command: load VECTOR_LENGTH weights
- start_infer  in  1  one-cycle command: stream one vector and fetch the result
- busy  out  1  high in any state other than IDLE
- cmd_dropped  out  1  one-cycle pulse when a command is ignored
- s_w_valid  in  1  weight stream valid
- s_w_ready  out  1  weight stream ready
- s_w_data  in  WEIGHTS_WIDTH  weight value
- s_v_valid  in  1  vector beat valid
- s_v_ready  out  1  vector beat ready
- s_v_data  in  DATA_IN_WIDTH*DATA_IN_LANES  one beat (lane 0 in LSBs)
- mem_wen  out  1  to perceptron mem_wen
- mem_ren  out  1  to perceptron mem_ren; tied 0
- mem_addr  out  MEM_ADDR_WIDTH  to perceptron mem_addr
- mem_wdata  out  WEIGHTS_WIDTH  to perceptron mem_wdata
- data_valid  out  1  to perceptron data_valid
- data_in  out  DATA_IN_WIDTH*DATA_IN_LANES  to perceptron data_in
- status_ai_sum  in  SUM_WIDTH  from perceptron
- status_ai_comparator  in  1  from perceptron
- m_res_valid  out  1  result valid
- m_res_ready  in  1  result ready
- m_res_sum  out  SUM_WIDTH  captured sum
- m_res_cmp  out  1  captured comparator

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 and state IDLE. This includes mem_addr, mem_wdata, data_in, m_res_sum and m_res_cmp.
- Reset mid-operation aborts immediately; no partial transfer resumes afterwards.
- Registered outputs: every mem_* and data_* output is a flop.
- States: IDLE, LOAD_W, STREAM, WAIT, RESULT.
- IDLE:
  - start_load takes priority and moves to LOAD_W; the weight counter clears.
  - Otherwise start_infer moves to STREAM; the beat counter clears.
  - If both are asserted together, load wins, start_infer is ignored and cmd_dropped pulses.
- Commands outside IDLE: any start_* is ignored and cmd_dropped pulses the next cycle.
- LOAD_W:
  - s_w_ready=1.
  - Each handshake (s_w_valid&s_w_ready) drives, in the next cycle, mem_wen=1, mem_addr=WEIGHT_BASE+wcnt and mem_wdata=s_w_data. wcnt then increments.
  - With no handshake, mem_wen=0 and addr/wdata hold their values.
  - Address arithmetic is modulo 2^MEM_ADDR_WIDTH (wraps).
  - After the VECTOR_LENGTH-th handshake: go to IDLE and drop s_w_ready in the same edge. The final mem_wen pulse appears in the first IDLE cycle.
- STREAM:
  - s_v_ready=1.
  - Each handshake drives, in the next cycle, data_valid=1 and data_in=s_v_data.
  - Source bubbles produce data_valid=0 cycles; data_in holds its value.
  - After the VECTOR_LENGTH/DATA_IN_LANES-th beat: go to WAIT and load the wait counter with RESULT_WAIT.
- WAIT:
  - The counter decrements each cycle.
  - The cycle it reaches 1, capture status_ai_sum into m_res_sum and status_ai_comparator into m_res_cmp, then go to RESULT.
- RESULT:
  - m_res_valid=1; m_res_sum/m_res_cmp are stable.
  - On m_res_ready, go to IDLE and clear m_res_valid next cycle.
  - Holding m_res_ready=1 while entering RESULT gives a one-cycle m_res_valid.
- Memory port: mem_ren is constant 0. mem_wen is never asserted outside the cycle following a LOAD_W handshake. The driver therefore never contends with the perceptron's internal SRAM lock during STREAM/WAIT.
- Throughput: one weight or one beat per cycle when the source is continuously valid.
- busy: combinational from the state register; deasserts the cycle after the LOAD_W→IDLE or RESULT→IDLE transition.

Test Plan:
- Weight load: start_load, 64 back-to-back weights 0x01..0x40 → 64 consecutive mem_wen pulses, addr 0..63, wdata matching, s_w_ready low afterwards, busy low one cycle after the last handshake.
- Throttled load: s_w_valid toggling every other cycle, WEIGHT_BASE=0xFFF0 → 64 writes with gaps, addresses 0xFFF0..0xFFFF then wrapping to 0x0000..0x002F, no extra pulses.
- Inference: weights all 1, 16 beats of 0x01010101, threshold 32 → 16 data_valid pulses, m_res_valid RESULT_WAIT cycles after the last beat, m_res_sum=64, m_res_cmp=1.
- Result backpressure: hold m_res_ready=0 for 20 cycles → m_res_valid and m_res_sum stable; a start_infer issued in that window gives cmd_dropped=1 and no data_valid.
- Simultaneous commands: start_load and start_infer in the same IDLE cycle → LOAD_W entered, cmd_dropped pulses once, no data_valid during the load.
- Async reset: assert rst_n=0 mid-STREAM after 5 beats → all outputs 0 immediately, no clock edge needed; a subsequent start_infer streams a full 16 beats.
